// File: rtl/camlcd_pkg.sv
// Shared camera/LCD definitions: FSM encoding, word packing field positions
// (common to the write arbiter and the read unpacker) and default frame geometry.
package camlcd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int PIX_W    = 10;
  localparam int G_HALF_W = 5;

  // word 1 = {unused, G[9:5], B}, word 2 = {unused, G[4:0], R}
  localparam int W1_G_LSB = 10;
  localparam int W1_B_LSB = 0;
  localparam int W2_G_LSB = 10;
  localparam int W2_R_LSB = 0;

  localparam int LCD_H            = 800;
  localparam int LCD_V            = 480;
  localparam int DEF_FRAME_PIXELS = LCD_H * LCD_V;
  localparam int DEF_CNT_W        = 19;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pixel_t;

  // Bit 15 of each word carries nothing, so only the low 15 bits are taken.
  function automatic pixel_t unpack_words(input logic [14:0] w1, input logic [14:0] w2);
    pixel_t p;
    p.g = {w1[W1_G_LSB +: G_HALF_W], w2[W2_G_LSB +: G_HALF_W]};
    p.b = w1[W1_B_LSB +: PIX_W];
    p.r = w2[W2_R_LSB +: PIX_W];
    return p;
  endfunction

endpackage

// File: rtl/sdram_pixel_unpacker_pix_buf.sv
// pix_buf: small synchronous FIFO of unpacked pixels (DEPTH x 30 bits).
// dout is the current head; a simultaneous push and pop leaves the count
// unchanged and the pop returns the old head. clear wins over push/pop.
module pix_buf
  import camlcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  pixel_t                 din,
  output pixel_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  pixel_t           mem_q [DEPTH];
  pixel_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  // next storage, pointer and occupancy values
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_push = push && ((cnt_q != DEPTH_C) || pop);
    do_pop  = pop && (cnt_q != '0);
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // register storage and pointers
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/sdram_pixel_unpacker.sv
// sdram_pixel_unpacker: pops paired words from the two SDRAM read FIFOs,
// unpacks them into a prefetch buffer and serves one pixel per LCD request.
// Optional build macro PIX_UNDERFLOW_CNT_EN enables the saturating underflow
// counter on oUnderflow_cnt; without it the port is tied to 0.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | after reset, waiting for the first frame start
// PREFETCH | filling the buffer ahead of the first LCD request
// RUN      | fetching and delivering the frame
// DONE     | whole frame delivered, no fetching, requests answered with 0s
module sdram_pixel_unpacker
  import camlcd_pkg::*;
#(
  parameter int BUF_DEPTH    = 4,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iFrame_start,
  input  logic        iPix_req,
  input  logic        iRd1_empty,
  input  logic        iRd2_empty,
  input  logic [15:0] iRd1_data,
  input  logic [15:0] iRd2_data,
  output logic        oRd_req,
  output logic        oPix_valid,
  output logic [9:0]  oR,
  output logic [9:0]  oG,
  output logic [9:0]  oB,
  output logic        oUnderflow,
  output logic        oFrame_err,
  output logic [15:0] oUnderflow_cnt
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0]      DEPTH_L = (CW+1)'(BUF_DEPTH);
  localparam logic [CNT_W:0]   FRAME_L = (CNT_W+1)'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_PIXELS);

  state_e           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] fetched_q, fetched_d;
  logic [CNT_W-1:0] delivered_q, delivered_d;
  logic             pix_valid_q, pix_valid_d;
  pixel_t           pix_q, pix_d;
  logic             underflow_q, underflow_d;
  logic             frame_err_q, frame_err_d;

  logic             rd_req;
  logic             buf_push, buf_pop, buf_clear;
  logic             buf_full, buf_empty;
  logic [CW-1:0]    buf_count;
  pixel_t           buf_head, buf_din;
  logic [CW:0]      occ_sum;
  logic [CNT_W:0]   fet_sum;
  logic             unused_bit15;

  assign unused_bit15 = iRd1_data[15] ^ iRd2_data[15];
  assign buf_din      = unpack_words(iRd1_data[14:0], iRd2_data[14:0]);
  assign occ_sum      = {1'b0, buf_count} + (CW+1)'(inflight_q);
  assign fet_sum      = {1'b0, fetched_q} + (CNT_W+1)'(inflight_q);

  pix_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .push   (buf_push),
    .pop    (buf_pop),
    .clear  (buf_clear),
    .din    (buf_din),
    .dout   (buf_head),
    .full   (buf_full),
    .empty  (buf_empty),
    .count  (buf_count)
  );

  // FSM state register
  always_ff @(posedge iClk) begin
    if (!iRst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; a frame start restarts prefetch from any state
  always_comb begin
    state_d = state_q;
    if (iFrame_start) begin
      state_d = PREFETCH;
    end else begin
      case (state_q)
        PREFETCH: if (buf_full || iPix_req)      state_d = RUN;
        RUN:      if (delivered_q == FRAME_C)    state_d = DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM output: pop both FIFOs while there is room and the frame is not fully fetched
  always_comb begin
    rd_req = 1'b0;
    if ((state_q == PREFETCH || state_q == RUN) && !iRd1_empty && !iRd2_empty &&
        (occ_sum < DEPTH_L) && (fet_sum < FRAME_L)) begin
      rd_req = 1'b1;
    end
  end

  // buffer control, pixel output and frame bookkeeping; frame start beats a same-cycle request
  always_comb begin
    buf_clear   = iFrame_start;
    buf_push    = inflight_q && !iFrame_start;
    buf_pop     = iPix_req && !buf_empty && !iFrame_start;
    inflight_d  = rd_req;
    pix_valid_d = iPix_req;
    pix_d       = pix_q;
    underflow_d = underflow_q;
    frame_err_d = iFrame_start && (state_q == PREFETCH || state_q == RUN);
    fetched_d   = fetched_q;
    delivered_d = delivered_q;

    if (iPix_req) begin
      pix_d = (iFrame_start || buf_empty) ? '0 : buf_head;
    end

    if (iFrame_start) begin
      underflow_d = 1'b0;
      fetched_d   = '0;
      delivered_d = '0;
    end else begin
      if (iPix_req && buf_empty)            underflow_d = 1'b1;
      if (buf_push && (fetched_q != '1))    fetched_d   = fetched_q + CNT_W'(1);
      if (buf_pop && (delivered_q != '1))   delivered_d = delivered_q + CNT_W'(1);
    end
  end

  // datapath registers
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      inflight_q  <= 1'b0;
      fetched_q   <= '0;
      delivered_q <= '0;
      pix_valid_q <= 1'b0;
      pix_q       <= '0;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      fetched_q   <= fetched_d;
      delivered_q <= delivered_d;
      pix_valid_q <= pix_valid_d;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef PIX_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // saturating count of requests that found the buffer empty
  always_comb begin
    ucnt_d = ucnt_q;
    if (iFrame_start)                                   ucnt_d = '0;
    else if (iPix_req && buf_empty && (ucnt_q != '1))   ucnt_d = ucnt_q + 16'd1;
  end

  // underflow count register
  always_ff @(posedge iClk) begin
    if (!iRst_n) ucnt_q <= '0;
    else         ucnt_q <= ucnt_d;
  end

  assign oUnderflow_cnt = ucnt_q;
`else
  assign oUnderflow_cnt = '0;
`endif

  assign oRd_req    = rd_req;
  assign oPix_valid = pix_valid_q;
  assign oR         = pix_q.r;
  assign oG         = pix_q.g;
  assign oB         = pix_q.b;
  assign oUnderflow = underflow_q;
  assign oFrame_err = frame_err_q;

endmodule

// File: tb/tb_sdram_pixel_unpacker.sv
// Scoreboard bench for sdram_pixel_unpacker (BUF_DEPTH=4, 16-pixel frames).
module tb_sdram_pixel_unpacker;
  import camlcd_pkg::*;

  localparam int BUF_DEPTH = 4;
  localparam int FP        = 16;
  localparam int CNT_W     = 5;
`ifdef PIX_UNDERFLOW_CNT_EN
  localparam int UCNT_EXP = 10 - BUF_DEPTH + 1;
`else
  localparam int UCNT_EXP = 0;
`endif

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iFrame_start = 1'b0;
  logic        iPix_req = 1'b0;
  logic        iRd1_empty = 1'b1;
  logic        iRd2_empty = 1'b1;
  logic [15:0] iRd1_data = '0;
  logic [15:0] iRd2_data = '0;
  logic        oRd_req, oPix_valid, oUnderflow, oFrame_err;
  logic [9:0]  oR, oG, oB;
  logic [15:0] oUnderflow_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int pop_idx  = 0;
  int rd_cnt   = 0;
  int pat      = 0;
  logic [29:0] exp_q[$];

  always #5 iClk = ~iClk;

  sdram_pixel_unpacker #(
    .BUF_DEPTH    (BUF_DEPTH),
    .FRAME_PIXELS (FP),
    .CNT_W        (CNT_W)
  ) dut (
    .iClk           (iClk),
    .iRst_n         (iRst_n),
    .iFrame_start   (iFrame_start),
    .iPix_req       (iPix_req),
    .iRd1_empty     (iRd1_empty),
    .iRd2_empty     (iRd2_empty),
    .iRd1_data      (iRd1_data),
    .iRd2_data      (iRd2_data),
    .oRd_req        (oRd_req),
    .oPix_valid     (oPix_valid),
    .oR             (oR),
    .oG             (oG),
    .oB             (oB),
    .oUnderflow     (oUnderflow),
    .oFrame_err     (oFrame_err),
    .oUnderflow_cnt (oUnderflow_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Indexed word pair k: w1 = {6'b0, k}, w2 = {0, 5'd3, 0x100+k} -> R=0x100+k, G=3, B=k
  function automatic logic [29:0] pk(input int k);
    logic [9:0] r, b;
    r = 10'(32'h100 + k);
    b = 10'(k);
    return {r, 10'h003, b};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic pulse_start();
    iFrame_start = 1'b1;
    tick();
    iFrame_start = 1'b0;
  endtask

  task automatic req(input logic [29:0] e);
    iPix_req = 1'b1;
    exp_q.push_back(e);
    tick();
    iPix_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(oPix_valid), 0);
    chk({tag, "_rgb"}, 32'({oR, oG, oB}), 0);
    chk({tag, "_underflow"}, 32'(oUnderflow), 0);
    chk({tag, "_frame_err"}, 32'(oFrame_err), 0);
    chk({tag, "_ucnt"}, 32'(oUnderflow_cnt), 0);
    chk({tag, "_rd_req"}, 32'(oRd_req), 0);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  // read FIFO model: a pop seen this cycle presents the next word pair in the next cycle
  initial begin
    forever begin
      @(negedge iClk);
      if (oRd_req) begin
        @(posedge iClk);
        #1;
        case (pat)
          0: begin iRd1_data = 16'h7C00; iRd2_data = 16'h03FF; end
          1: begin iRd1_data = 16'hFC00; iRd2_data = 16'h83FF; end
          default: begin
            iRd1_data = {6'b0, 10'(pop_idx)};
            iRd2_data = {1'b0, 5'd3, 10'(32'h100 + pop_idx)};
          end
        endcase
        pop_idx++;
        rd_cnt++;
      end
    end
  end

  // monitor: every valid pixel is matched against the oldest expectation
  initial begin
    logic [29:0] e;
    forever begin
      @(negedge iClk);
      if (oPix_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pix_unexpected: got %h expected no pixel", {oR, oG, oB});
        end else begin
          e = exp_q.pop_front();
          chk("pix_rgb", 32'({oR, oG, oB}), 32'(e));
        end
      end
    end
  end

  initial begin
    int base;
    int snap;

    // reset
    tick(3);
    chk_reset_outputs("reset");
    iRst_n = 1'b1;
    iRd1_empty = 1'b0;
    iRd2_empty = 1'b0;
    tick(2);
    chk("idle_no_fetch", 32'(oRd_req), 0);

    // T1: plain unpack after prefetch; prefetch stops at BUF_DEPTH words
    pat  = 0;
    snap = rd_cnt;
    pulse_start();
    chk("t1_frame_err", 32'(oFrame_err), 0);
    tick(10);
    chk("t1_prefetch_cnt", 32'(rd_cnt - snap), BUF_DEPTH);
    req({10'h3FF, 10'h3E0, 10'h000});
    tick(3);
    chk("t1_underflow", 32'(oUnderflow), 0);
    tick(5);

    // T2: bit 15 set in both words is ignored; restart from RUN flags a frame error
    pat = 1;
    pulse_start();
    chk("t2_frame_err", 32'(oFrame_err), 1);
    tick();
    chk("t2_frame_err_pulse", 32'(oFrame_err), 0);
    tick(9);
    req({10'h3FF, 10'h3E0, 10'h000});
    req({10'h3FF, 10'h3E0, 10'h000});
    tick(10);

    // T3: FIFO 2 empty for 10 requested cycles, then one more request as it refills
    pat  = 2;
    base = pop_idx;
    pulse_start();
    chk("t3_frame_err", 32'(oFrame_err), 1);
    tick(10);
    chk("t3_full", 32'(dut.u_buf.full), 1);
    iRd2_empty = 1'b1;
    for (int i = 0; i < 10; i++) req(i < BUF_DEPTH ? pk(base + i) : 30'h0);
    iRd2_empty = 1'b0;
    req(30'h0);
    tick(3);
    chk("t3_underflow", 32'(oUnderflow), 1);
    chk("t3_ucnt", 32'(oUnderflow_cnt), UCNT_EXP);
    tick(10);

    // T4: a 16-pixel frame fetches exactly 16 words, then DONE answers with 0s
    base = pop_idx;
    snap = rd_cnt;
    pulse_start();
    chk("t4_underflow_cleared", 32'(oUnderflow), 0);
    chk("t4_ucnt_cleared", 32'(oUnderflow_cnt), 0);
    tick(10);
    for (int i = 0; i < FP; i++) begin
      req(pk(base + i));
      tick();
    end
    tick(4);
    chk("t4_state_done", 32'(dut.state_q), 32'(DONE));
    chk("t4_rd_pulses", 32'(rd_cnt - snap), FP);
    chk("t4_underflow_before", 32'(oUnderflow), 0);
    req(30'h0);
    tick(2);
    chk("t4_underflow_after", 32'(oUnderflow), 1);
    chk("t4_rd_none_done", 32'(rd_cnt - snap), FP);

    // T5: restart with a read in flight discards that word
    base = pop_idx;
    pulse_start();
    chk("t5_frame_err_from_done", 32'(oFrame_err), 0);
    tick(10);
    for (int i = 0; i < 5; i++) begin
      req(pk(base + i));
      tick();
    end
    chk("t5_inflight", 32'(dut.inflight_q), 1);
    pulse_start();
    chk("t5_frame_err", 32'(oFrame_err), 1);
    chk("t5_buf_empty", 32'(dut.u_buf.empty), 1);
    tick(10);
    req(pk(base + 9));
    tick(3);

    // T6: reset in the middle of RUN
    chk("t6_state_run", 32'(dut.state_q), 32'(RUN));
    req(pk(base + 10));
    iRst_n = 1'b0;
    tick();
    chk_reset_outputs("t6");
    iRst_n = 1'b1;
    tick(3);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
